// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB around a shared ALU and memory port.
// Define MEM_TIMEOUT_EN to trap to TRAP/bus_err when a req/ack handshake exceeds TIMEOUT_CYCLES.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] imem_opcode,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    input  logic       branch_taken,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       alu_a_sel,
    output logic       alu_b_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    if (TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_to_range
        $error("TIMEOUT_CYCLES does not fit in a TO_W-bit counter");
    end

    state_e     state_q, state_d;
    logic [6:0] opc_q, opc_d;
    logic       illegal_q, illegal_d;
    logic       bus_err_q, bus_err_d;
    logic       timeout;

    function automatic logic is_legal(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_SYSTEM: is_legal = 1'b1;
            default:                                              is_legal = 1'b0;
        endcase
    endfunction

`ifdef MEM_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            waiting;

    // Counter is zero outside a stalled handshake, so entry to FETCH/MEM always starts from 0.
    always_comb begin
        waiting  = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);
        to_cnt_d = waiting ? to_cnt_q + 1'b1 : '0;
        timeout  = waiting && (to_cnt_q == TO_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET;
            opc_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        retire    = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    opc_d   = imem_opcode;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end

            S_DECODE: begin
                if (is_legal(opc_q)) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end

            S_EXEC: begin
                state_d = S_WB;
                case (opc_q)
                    OPC_OPIMM, OPC_JALR: alu_b_sel = 1'b1;
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel = 1'b1;
                        state_d   = S_MEM;
                    end
                    OPC_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    OPC_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? 2'b01 : 2'b00;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = (opc_q == OPC_STORE);
                alu_b_sel = 1'b1;
                if (dmem_ack) begin
                    if (opc_q == OPC_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end
            end

            S_WB: begin
                pc_we   = 1'b1;
                retire  = 1'b1;
                rf_we   = (opc_q != OPC_SYSTEM);
                state_d = S_FETCH;
                case (opc_q)
                    OPC_LOAD: wb_sel = 2'b01;
                    OPC_JAL: begin
                        wb_sel = 2'b10;
                        pc_sel = 2'b01;
                    end
                    OPC_JALR: begin
                        wb_sel = 2'b10;
                        pc_sel = 2'b10;
                    end
                    OPC_LUI: wb_sel = 2'b11;
                    default: ;
                endcase
            end

            S_TRAP: ;

            default: state_d = S_RESET;
        endcase
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle stimulus and expected outputs are queued
// together by each scenario task, then replayed and compared one clock at a time.
module tb_multicycle_ctrl;

    localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

    localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LOAD = 7'b0000011,
                           STORE = 7'b0100011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                           JAL = 7'b1101111, JALR = 7'b1100111, BRANCH = 7'b1100011,
                           SYSTEM = 7'b1110011, BAD = 7'b0000000;

    // Observation vector: {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
    //                      alu_a_sel, alu_b_sel, rf_we, wb_sel, retire, illegal, bus_err}
    typedef logic [17:0] obs_t;

    typedef struct packed {
        logic       rst;
        logic       imem_ack;
        logic [6:0] opcode;
        logic       dmem_ack;
        logic       branch_taken;
    } stim_t;

    localparam obs_t O_IREQ = obs_t'(1) << 14;
    localparam obs_t O_DREQ = obs_t'(1) << 13;
    localparam obs_t O_DWE  = obs_t'(1) << 12;
    localparam obs_t O_IRWE = obs_t'(1) << 11;
    localparam obs_t O_PCWE = obs_t'(1) << 10;
    localparam obs_t O_A    = obs_t'(1) << 7;
    localparam obs_t O_B    = obs_t'(1) << 6;
    localparam obs_t O_RFWE = obs_t'(1) << 5;
    localparam obs_t O_RET  = obs_t'(1) << 2;
    localparam obs_t O_ILL  = obs_t'(1) << 1;
    localparam obs_t O_BERR = obs_t'(1);
    localparam obs_t ALL    = '1;
    localparam obs_t NO_ALU = ~(O_A | O_B);
    localparam obs_t NO_WBS = ~(obs_t'(3) << 3);

    function automatic obs_t st(input logic [2:0] s);
        return obs_t'(s) << 15;
    endfunction
    function automatic obs_t pcs(input logic [1:0] v);
        return obs_t'(v) << 8;
    endfunction
    function automatic obs_t wbs(input logic [1:0] v);
        return obs_t'(v) << 3;
    endfunction
    function automatic stim_t mk(input logic r, input logic ia, input logic [6:0] opc,
                                 input logic da, input logic bt);
        stim_t s;
        s.rst = r; s.imem_ack = ia; s.opcode = opc; s.dmem_ack = da; s.branch_taken = bt;
        return s;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] imem_opcode = '0;
    logic       imem_ack = 1'b0, dmem_ack = 1'b0, branch_taken = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_a_sel, alu_b_sel;
    logic       rf_we, retire, illegal, bus_err;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    obs_t  care_q[$];

    multicycle_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .imem_opcode(imem_opcode), .imem_req(imem_req),
        .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .branch_taken(branch_taken), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .retire(retire), .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic push(input stim_t s, input obs_t e, input obs_t care);
        stim_q.push_back(s);
        exp_q.push_back(e);
        care_q.push_back(care);
    endtask

    // Drive each queued cycle on the falling edge, sample 1ns later, compare against the scoreboard.
    task automatic run(input string name);
        int   n = 0;
        stim_t s;
        obs_t e, c, o;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            c = care_q.pop_front();
            @(negedge clk);
            rst          = s.rst;
            imem_ack     = s.imem_ack;
            imem_opcode  = s.opcode;
            dmem_ack     = s.dmem_ack;
            branch_taken = s.branch_taken;
            #1;
            o = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel,
                 alu_a_sel, alu_b_sel, rf_we, wb_sel, retire, illegal, bus_err};
            checks++;
            if ((o & c) !== (e & c)) begin
                errors++;
                $display("FAIL %s[%0d]: got %b expected %b (care %b)", name, n, o, e, c);
            end
            n++;
        end
    endtask

    task automatic q_fetch(input int nwait, input logic [6:0] opc);
        for (int i = 0; i < nwait; i++) push(mk(0, 0, opc, 0, 0), st(S_FETCH) | O_IREQ, ALL);
        push(mk(0, 1, opc, 0, 0), st(S_FETCH) | O_IREQ | O_IRWE, ALL);
        push(mk(0, 0, 7'h7f, 0, 0), st(S_DECODE), ALL);
    endtask

    task automatic q_alu_op(input logic [6:0] opc, input int nwait, input obs_t ex_e,
                            input obs_t ex_c, input obs_t wb_e, input obs_t wb_c);
        q_fetch(nwait, opc);
        push(mk(0, 0, 0, 0, 0), st(S_EXEC) | ex_e, ex_c);
        push(mk(0, 0, 0, 0, 0), st(S_WB) | O_PCWE | O_RET | wb_e, wb_c);
    endtask

    task automatic q_reset_release;
        push(mk(1, 0, 0, 0, 0), '0, ALL);
        push(mk(0, 0, 0, 0, 0), st(S_RESET), ALL);
        push(mk(0, 0, 0, 0, 0), st(S_FETCH) | O_IREQ, ALL);
    endtask

    task automatic test_reset;
        push(mk(1, 0, 0, 0, 0), '0, ALL);
        q_reset_release();
        run("reset");
    endtask

    task automatic test_addi;
        q_alu_op(OPIMM, 0, O_B, ALL, O_RFWE | pcs(2'b00) | wbs(2'b00), ALL);
        run("addi");
    endtask

    task automatic test_branch;
        q_fetch(1, BRANCH);
        push(mk(0, 0, 0, 0, 1), st(S_EXEC) | O_PCWE | pcs(2'b01) | O_RET, ALL);
        q_fetch(0, BRANCH);
        push(mk(0, 0, 0, 0, 0), st(S_EXEC) | O_PCWE | pcs(2'b00) | O_RET, ALL);
        run("branch");
    endtask

    task automatic test_load_store;
        q_fetch(0, LOAD);
        push(mk(0, 0, 0, 0, 0), st(S_EXEC) | O_B, ALL);
        for (int i = 0; i < 3; i++) push(mk(0, 0, 0, 0, 0), st(S_MEM) | O_DREQ | O_B, ALL);
        push(mk(0, 0, 0, 1, 0), st(S_MEM) | O_DREQ | O_B, ALL);
        push(mk(0, 0, 0, 0, 0), st(S_WB) | O_PCWE | O_RFWE | wbs(2'b01) | O_RET, ALL);
        q_fetch(0, STORE);
        push(mk(0, 0, 0, 0, 0), st(S_EXEC) | O_B, ALL);
        push(mk(0, 0, 0, 1, 0), st(S_MEM) | O_DREQ | O_DWE | O_B | O_PCWE | O_RET, ALL);
        push(mk(0, 0, 0, 0, 0), st(S_FETCH) | O_IREQ, ALL);
        run("load_store");
    endtask

    task automatic test_other_ops;
        q_alu_op(OP,     0, '0,        ALL,    O_RFWE | wbs(2'b00),                ALL);
        q_alu_op(AUIPC,  1, O_A | O_B, ALL,    O_RFWE | wbs(2'b00),                ALL);
        q_alu_op(LUI,    0, '0,        NO_ALU, O_RFWE | wbs(2'b11),                ALL);
        q_alu_op(JAL,    2, '0,        NO_ALU, O_RFWE | wbs(2'b10) | pcs(2'b01),   ALL);
        q_alu_op(JALR,   0, O_B,       ALL,    O_RFWE | wbs(2'b10) | pcs(2'b10),   ALL);
        q_alu_op(SYSTEM, 0, '0,        NO_ALU, pcs(2'b00),                         NO_WBS);
        run("other_ops");
    endtask

    task automatic test_reset_mid_mem;
        q_fetch(0, LOAD);
        push(mk(0, 0, 0, 0, 0), st(S_EXEC) | O_B, ALL);
        push(mk(0, 0, 0, 0, 0), st(S_MEM) | O_DREQ | O_B, ALL);
        push(mk(1, 0, 0, 0, 0), '0, ALL);
        push(mk(1, 0, 0, 0, 0), '0, ALL);
        push(mk(0, 0, 0, 1, 0), st(S_RESET), ALL);
        push(mk(0, 0, 0, 0, 0), st(S_FETCH) | O_IREQ, ALL);
        run("reset_mid_mem");
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        q_alu_op(OPIMM, 3, O_B, ALL, O_RFWE, ALL);
        for (int i = 0; i < 4; i++) push(mk(0, 0, OP, 0, 0), st(S_FETCH) | O_IREQ, ALL);
        push(mk(0, 0, 0, 0, 0), st(S_TRAP) | O_BERR, ALL);
        push(mk(0, 1, OP, 0, 0), st(S_TRAP) | O_BERR, ALL);
        q_reset_release();
        run("timeout");
    endtask
`else
    task automatic test_timeout;
        q_alu_op(OP, 12, '0, ALL, O_RFWE, ALL);
        run("long_stall");
    endtask
`endif

    task automatic test_illegal;
        q_fetch(0, BAD);
        push(mk(0, 0, 0, 0, 0), st(S_TRAP) | O_ILL, ALL);
        push(mk(0, 1, OP, 0, 0), st(S_TRAP) | O_ILL, ALL);
        push(mk(0, 0, 0, 1, 1), st(S_TRAP) | O_ILL, ALL);
        push(mk(0, 0, 0, 0, 0), st(S_TRAP) | O_ILL, ALL);
        q_reset_release();
        run("illegal");
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_load_store();
        test_other_ops();
        test_reset_mid_mem();
        test_timeout();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
